spi_slave: RTL

Peripheral-side (slave) SPI endpoint for the SPI master core. It samples an externally driven SPI clock, chip select and MOSI inside the system clock domain. It shifts received bits into bytes and presents each as a one-cycle valid pulse, and drives MISO from a one-byte holding register loaded through a ready/valid handshake. It sits between the SPI pins and a local register or FIFO client, and is the bench responder for master-core verification.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_slave.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types, mode decode helpers and constants
package spi_pkg;

    typedef enum logic [1:0] {
        SPI_MODE0 = 2'd0,
        SPI_MODE1 = 2'd1,
        SPI_MODE2 = 2'd2,
        SPI_MODE3 = 2'd3
    } spi_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam int SPI_BITS = 8;

    function automatic logic cpol(input spi_mode_e mode);
        return (mode == SPI_MODE2) || (mode == SPI_MODE3);
    endfunction

    function automatic logic cpha(input spi_mode_e mode);
        return (mode == SPI_MODE1) || (mode == SPI_MODE3);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchronizer with registered-history edge detect
module spi_sync_edge #(
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_LEVEL;
            sync_q <= RESET_LEVEL;
            prev_q <= RESET_LEVEL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave endpoint; optional o_TX_Underrun via SPI_SLAVE_UNDERRUN_EN
module spi_slave
    import spi_pkg::*;
#(
    parameter int SPI_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_SPI_Clk,
    input  logic                i_SPI_CS_n,
    input  logic                i_SPI_MOSI,
    output logic                o_SPI_MISO,
    output logic                o_SPI_MISO_En,
    input  logic                i_TX_DV,
    input  logic [SPI_BITS-1:0] i_TX_Byte,
    output logic                o_TX_Ready,
    output logic                o_RX_DV,
    output logic [SPI_BITS-1:0] o_RX_Byte
`ifdef SPI_SLAVE_UNDERRUN_EN
    ,
    output logic                o_TX_Underrun
`endif
);

    localparam spi_mode_e MODE  = spi_mode_e'(SPI_MODE[1:0]);
    localparam logic      CPOL  = cpol(MODE);
    localparam logic      CPHA  = cpha(MODE);
    localparam int        CNT_W = $clog2(SPI_BITS);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic mosi_meta_q, mosi_q;

    spi_sync_edge #(.RESET_LEVEL(CPOL)) u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (i_SPI_Clk),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.RESET_LEVEL(1'b1)) u_cs_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (i_SPI_CS_n),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_meta_q <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            mosi_meta_q <= i_SPI_MOSI;
            mosi_q      <= mosi_meta_q;
        end
    end

    // lead = leaving the idle level of the SPI clock, trail = returning to it
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    spi_state_e          state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SPI_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [SPI_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                rx_dv_q, rx_dv_d;
    logic [SPI_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_BITS-1:0] hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                load;
    logic                tx_accept;

    assign tx_accept = i_TX_DV && !hold_valid_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;
        tx_shift_d = tx_shift_q;
        load       = 1'b0;
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (cs_fall) begin
                    state_d = ACTIVE;
                    load    = !CPHA;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = '0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift_q[SPI_BITS-2:0], mosi_q};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(SPI_BITS - 1)) begin
                            rx_byte_d = {rx_shift_q[SPI_BITS-2:0], mosi_q};
                            rx_dv_d   = 1'b1;
                        end
                    end
                    // a shift edge at count 0 is a byte boundary in both phases
                    if (shift_edge) begin
                        if (bit_cnt_q == '0) begin
                            load = 1'b1;
                        end else begin
                            tx_shift_d = {tx_shift_q[SPI_BITS-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            tx_shift_d = hold_valid_q ? hold_q : '0;
        end
    end

    // a same-cycle write lands after the load has taken the old contents
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (tx_accept) begin
            hold_d       = i_TX_Byte;
            hold_valid_d = 1'b1;
        end else if (load) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            rx_byte_q    <= '0;
            rx_dv_q      <= 1'b0;
            tx_shift_q   <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_dv_q      <= rx_dv_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic underrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_q <= 1'b0;
        end else if (load && !hold_valid_q) begin
            underrun_q <= 1'b1;
        end else if (tx_accept) begin
            underrun_q <= 1'b0;
        end
    end

    assign o_TX_Underrun = underrun_q;
`endif

    assign o_SPI_MISO    = (state_q == ACTIVE) && tx_shift_q[SPI_BITS-1];
    assign o_SPI_MISO_En = (state_q == ACTIVE);
    assign o_TX_Ready    = !hold_valid_q;
    assign o_RX_DV       = rx_dv_q;
    assign o_RX_Byte     = rx_byte_q;

endmodule
